// File: rtl/freq_meas_pkg.sv
// Shared types and defaults for the reciprocal frequency-meter controller.
package freq_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GATE      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_HOLD      = 2'd3
    } state_e;

    // Gate lengths in clk_fs cycles: 10 ms, 100 ms, 1 s, 10 s at 50 MHz.
    localparam logic [31:0] DEF_GATE_LEN [4] = '{
        32'd500_000,
        32'd5_000_000,
        32'd50_000_000,
        32'd500_000_000
    };

    localparam logic [31:0] DEF_TIMEOUT_CYC = 32'd100_000_000;

    // Timer preload for a gate: the timer counts len-1 down to 0, giving len cycles.
    function automatic logic [31:0] gate_load_val(
        input logic [1:0]  sel,
        input logic [31:0] len0,
        input logic [31:0] len1,
        input logic [31:0] len2,
        input logic [31:0] len3
    );
        logic [31:0] len;
        case (sel)
            2'd0:    len = len0;
            2'd1:    len = len1;
            2'd2:    len = len2;
            default: len = len3;
        endcase
        return len - 32'd1;
    endfunction

endpackage

// File: rtl/freq_meas_timer.sv
// 32-bit loadable down-counter with zero flag; stops at 0 instead of wrapping.
module freq_meas_timer (
    input  logic        clk_fs,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        en,
    output logic        zero
);

    logic [31:0] cnt_q, cnt_d;

    // Load has priority over counting; counting holds at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != 32'd0)) begin
            cnt_d = cnt_q - 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_fs or posedge rst) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 32'd0);

endmodule

// File: rtl/freq_meas_ctrl.sv
// Gate/timeout sequencer for a frequency-meter datapath with a valid/ready result port.
module freq_meas_ctrl
    import freq_meas_pkg::*;
#(
    parameter logic [31:0] GATE_LEN0   = DEF_GATE_LEN[0],
    parameter logic [31:0] GATE_LEN1   = DEF_GATE_LEN[1],
    parameter logic [31:0] GATE_LEN2   = DEF_GATE_LEN[2],
    parameter logic [31:0] GATE_LEN3   = DEF_GATE_LEN[3],
    parameter logic [31:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic        clk_fs,
    input  logic        rst,
    input  logic        start,
    input  logic        continuous,
    input  logic [1:0]  gate_sel,
    output logic        gate,
    input  logic        meas_done,
    input  logic [31:0] fs_cnt,
    input  logic [31:0] fx_cnt,
    input  logic [31:0] hi_cnt,
    output logic        busy,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_fs,
    output logic [31:0] res_fx,
    output logic [31:0] res_hi,
    output logic        res_err
);

    state_e      state_q, state_d;

    logic        tmr_load;
    logic [31:0] tmr_load_val;
    logic        tmr_en;
    logic        tmr_zero;
    logic        cap_done;
    logic        cap_tmo;

    logic [31:0] res_fs_q, res_fx_q, res_hi_q;
    logic        res_err_q;

    // One timer serves both the gate window and the meas_done timeout.
    freq_meas_timer u_timer (
        .clk_fs   (clk_fs),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    // State register.
    always_ff @(posedge clk_fs or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start only matters in IDLE, meas_done only in WAIT_DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start || continuous) state_d = ST_GATE;
            end
            ST_GATE: begin
                if (tmr_zero) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (meas_done || tmr_zero) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready) state_d = continuous ? ST_GATE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and timer/capture controls; the gate_sel latch is the timer preload itself.
    always_comb begin
        gate         = (state_q == ST_GATE);
        busy         = (state_q != ST_IDLE);
        res_valid    = (state_q == ST_HOLD);
        tmr_load     = 1'b0;
        tmr_load_val = gate_load_val(gate_sel, GATE_LEN0, GATE_LEN1, GATE_LEN2, GATE_LEN3);
        tmr_en       = 1'b0;
        cap_done     = 1'b0;
        cap_tmo      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start || continuous) tmr_load = 1'b1;
            end
            ST_GATE: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = TIMEOUT_CYC - 32'd1;
                end
            end
            ST_WAIT_DONE: begin
                tmr_en = 1'b1;
                // meas_done wins over a coincident timeout.
                if (meas_done)     cap_done = 1'b1;
                else if (tmr_zero) cap_tmo  = 1'b1;
            end
            ST_HOLD: begin
                if (res_ready && continuous) tmr_load = 1'b1;
            end
            default: ;
        endcase
    end

    // Result registers; only written on leaving WAIT_DONE so they stay frozen in HOLD.
    always_ff @(posedge clk_fs or posedge rst) begin
        if (rst) begin
            res_fs_q  <= 32'd0;
            res_fx_q  <= 32'd0;
            res_hi_q  <= 32'd0;
            res_err_q <= 1'b0;
        end else if (cap_done) begin
            res_fs_q  <= fs_cnt;
            res_fx_q  <= fx_cnt;
            res_hi_q  <= hi_cnt;
            res_err_q <= (fx_cnt == 32'd0);
        end else if (cap_tmo) begin
            res_fs_q  <= 32'd0;
            res_fx_q  <= 32'd0;
            res_hi_q  <= 32'd0;
            res_err_q <= 1'b1;
        end
    end

    assign res_fs  = res_fs_q;
    assign res_fx  = res_fx_q;
    assign res_hi  = res_hi_q;
    assign res_err = res_err_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed bench for freq_meas_ctrl with short gates (10/20/40/80) and a 16-cycle timeout.
module tb_freq_meas_ctrl;

    logic        clk_fs = 1'b0;
    logic        rst;
    logic        start;
    logic        continuous;
    logic [1:0]  gate_sel;
    logic        gate;
    logic        meas_done;
    logic [31:0] fs_cnt, fx_cnt, hi_cnt;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_fs, res_fx, res_hi;
    logic        res_err;

    int checks   = 0;
    int failures = 0;

    freq_meas_ctrl #(
        .GATE_LEN0   (32'd10),
        .GATE_LEN1   (32'd20),
        .GATE_LEN2   (32'd40),
        .GATE_LEN3   (32'd80),
        .TIMEOUT_CYC (32'd16)
    ) dut (
        .clk_fs     (clk_fs),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .gate_sel   (gate_sel),
        .gate       (gate),
        .meas_done  (meas_done),
        .fs_cnt     (fs_cnt),
        .fx_cnt     (fx_cnt),
        .hi_cnt     (hi_cnt),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_fs     (res_fs),
        .res_fx     (res_fx),
        .res_hi     (res_hi),
        .res_err    (res_err)
    );

    always #5 clk_fs = ~clk_fs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_fs);
        #1;
    endtask

    // Called with gate already high; returns the number of cycles it stays high.
    task automatic count_gate(output int n);
        n = 0;
        while (gate === 1'b1 && n < 300) begin
            n++;
            tick();
        end
    endtask

    // Returns the number of edges until res_valid is seen high.
    task automatic wait_valid(output int n);
        n = 0;
        while (res_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stable;
        int spurious;

        rst = 1'b1; start = 1'b0; continuous = 1'b0; gate_sel = 2'd0;
        meas_done = 1'b0; fs_cnt = '0; fx_cnt = '0; hi_cnt = '0; res_ready = 1'b0;
        repeat (3) tick();
        chk("rst_gate",  gate, 1'b0);
        chk("rst_busy",  busy, 1'b0);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_err",   res_err, 1'b0);
        chk("rst_fs",    res_fs, 32'd0);
        rst = 1'b0;
        tick();

        // Single shot, sel=1, meas_done 5 cycles after gate falls.
        gate_sel = 2'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_gate_rise", gate, 1'b1);
        chk("t1_busy", busy, 1'b1);
        count_gate(n);
        chk("t1_gate_len", n, 32'd20);
        repeat (4) tick();
        meas_done = 1'b1; fs_cnt = 32'd1000; fx_cnt = 32'd50; hi_cnt = 32'd400; res_ready = 1'b1;
        tick();
        meas_done = 1'b0;
        chk("t1_valid", res_valid, 1'b1);
        chk("t1_fs", res_fs, 32'd1000);
        chk("t1_fx", res_fx, 32'd50);
        chk("t1_hi", res_hi, 32'd400);
        chk("t1_err", res_err, 1'b0);
        tick();
        chk("t1_valid_drop", res_valid, 1'b0);
        chk("t1_idle", busy, 1'b0);

        // Timeout: no meas_done, inputs nonzero to prove the counts are cleared.
        res_ready = 1'b0; gate_sel = 2'd0; start = 1'b1;
        fs_cnt = 32'd77; fx_cnt = 32'd88; hi_cnt = 32'd99;
        tick();
        start = 1'b0;
        count_gate(n);
        chk("t2_gate_len", n, 32'd10);
        wait_valid(n);
        chk("t2_tmo_cycles", n, 32'd16);
        chk("t2_fs", res_fs, 32'd0);
        chk("t2_fx", res_fx, 32'd0);
        chk("t2_hi", res_hi, 32'd0);
        chk("t2_err", res_err, 1'b1);
        res_ready = 1'b1;
        tick();
        chk("t2_idle", busy, 1'b0);

        // meas_done on the expiry cycle wins; start pulsed mid-gate is ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        count_gate(n);
        chk("t3_gate_len", n, 32'd6);
        repeat (15) tick();
        meas_done = 1'b1; fs_cnt = 32'd123; fx_cnt = 32'd7; hi_cnt = 32'd3;
        tick();
        meas_done = 1'b0;
        chk("t3_valid", res_valid, 1'b1);
        chk("t3_fx", res_fx, 32'd7);
        chk("t3_fs", res_fs, 32'd123);
        chk("t3_err", res_err, 1'b0);
        tick();
        chk("t3_idle", busy, 1'b0);

        // fx_cnt = 0 flags an error even with meas_done.
        start = 1'b1;
        tick();
        start = 1'b0;
        count_gate(n);
        meas_done = 1'b1; fs_cnt = 32'd55; fx_cnt = 32'd0; hi_cnt = 32'd5;
        tick();
        meas_done = 1'b0;
        chk("t4_fs", res_fs, 32'd55);
        chk("t4_err", res_err, 1'b1);
        tick();
        chk("t4_idle", busy, 1'b0);

        // Continuous mode with backpressure and a mid-gate sel change.
        res_ready = 1'b0; gate_sel = 2'd0; continuous = 1'b1;
        tick();
        chk("t5_gate_rise", gate, 1'b1);
        n = 0;
        while (gate === 1'b1 && n < 300) begin
            if (n == 3) gate_sel = 2'd3;
            n++;
            tick();
        end
        chk("t5_gate_len", n, 32'd10);
        repeat (2) tick();
        meas_done = 1'b1; fs_cnt = 32'd11; fx_cnt = 32'd22; hi_cnt = 32'd33;
        tick();
        meas_done = 1'b0;
        chk("t5_valid", res_valid, 1'b1);
        stable = 0;
        for (int i = 0; i < 30; i++) begin
            fs_cnt = 32'd500 + i; fx_cnt = 32'd600 + i; hi_cnt = 32'd700 + i;
            meas_done = (i % 2 == 0);
            tick();
            if (res_valid === 1'b1 && res_fs === 32'd11 && res_fx === 32'd22 &&
                res_hi === 32'd33 && res_err === 1'b0 && gate === 1'b0)
                stable++;
        end
        meas_done = 1'b0;
        chk("t5_hold_stable", stable, 32'd30);
        res_ready = 1'b1;
        tick();
        continuous = 1'b0;
        chk("t5_regate", gate, 1'b1);
        chk("t5_valid_drop", res_valid, 1'b0);
        count_gate(n);
        chk("t5_gate2_len", n, 32'd80);
        wait_valid(n);
        chk("t5_tmo_cycles", n, 32'd16);
        chk("t5_err", res_err, 1'b1);
        tick();
        chk("t5_idle", busy, 1'b0);

        // Asynchronous reset at gate cycle 5 aborts without a result.
        gate_sel = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_gate_rise", gate, 1'b1);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("t6_gate_async", gate, 1'b0);
        chk("t6_busy_async", busy, 1'b0);
        chk("t6_valid_async", res_valid, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        spurious = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (gate !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) spurious++;
        end
        chk("t6_quiet", spurious, 32'd0);
        gate_sel = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        count_gate(n);
        chk("t6_gate_len", n, 32'd10);
        meas_done = 1'b1; fs_cnt = 32'd321; fx_cnt = 32'd9; hi_cnt = 32'd100;
        tick();
        meas_done = 1'b0;
        chk("t6_valid", res_valid, 1'b1);
        chk("t6_fx", res_fx, 32'd9);
        chk("t6_hi", res_hi, 32'd100);
        tick();
        chk("t6_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
